pipe_skid_reg: RTL and testbench

//  Generic pipeline-stage register for the five-stage CPU. Replaces the hand-written per-stage latches.

---
 rtl/pipe_skid_reg.sv | 119 +++++++++++
 tb/tb_pipe_skid_reg.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic pipeline-stage register with valid/ready flow
// control, optional 2-entry skid buffer, sync flush and stall counter.
module pipe_skid_reg #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 10,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                SKID        = 1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              ready_q;
    logic              accept;
    logic              issue;
    logic              ld_in;
    logic              ld_skid;
    logic              ld_fwd;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (SKID != 0) ? ready_q : (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;
    assign out_ctrl  = out_valid ? main_ctrl : BUBBLE_CTRL;
    assign out_data  = main_data;
    assign occupancy = state;

    // With SKID=0 in_ready is low whenever BUSY cannot issue, so FULL
    // is never entered and the skid registers stay idle.
    always_comb begin
        state_n = state;
        ld_in   = 1'b0;
        ld_skid = 1'b0;
        ld_fwd  = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n = BUSY;
                        ld_in   = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && issue) begin
                        ld_in = 1'b1;
                    end else if (issue) begin
                        state_n = EMPTY;
                    end else if (accept) begin
                        state_n = FULL;
                        ld_skid = 1'b1;
                    end
                end
                FULL: begin
                    if (issue) begin
                        state_n = BUSY;
                        ld_fwd  = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_ctrl <= BUBBLE_CTRL;
            main_data <= '0;
            skid_ctrl <= BUBBLE_CTRL;
            skid_data <= '0;
            stall_cnt <= '0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n != FULL);
            if (ld_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (ld_fwd) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (ld_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: self-checking bench for pipe_skid_reg using a
// queue-based reference model and three parameterisations.
module tb_pipe_skid_reg;

    localparam logic [9:0] BUB = 10'h155;

    typedef struct packed {
        logic [9:0]  c;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [9:0]  in_ctrl;
    logic [31:0] in_data;

    logic        r0, v0, r1, v1, r2, v2;
    logic [9:0]  c0, c1, c2;
    logic [31:0] d0, d1, d2;
    logic [1:0]  o0, o1, o2;
    logic [15:0] s0, s2;
    logic [3:0]  s1;

    int          sel;
    logic        s_ready, s_valid;
    logic [9:0]  s_ctrl;
    logic [31:0] s_data;
    logic [1:0]  s_occ;
    logic [15:0] s_stall;

    ent_t q[$];
    int   stall_exp;
    int   cnt_max;
    bit   skid_mode;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(10), .BUBBLE_CTRL(BUB),
                    .SKID(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v0), .out_ready(out_ready),
        .out_ctrl(c0), .out_data(d0),
        .occupancy(o0), .stall_cnt(s0)
    );

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(10), .BUBBLE_CTRL(BUB),
                    .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready),
        .out_ctrl(c1), .out_data(d1),
        .occupancy(o1), .stall_cnt(s1)
    );

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(10), .BUBBLE_CTRL(BUB),
                    .SKID(0), .CNT_W(16)) u_ns (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r2),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v2), .out_ready(out_ready),
        .out_ctrl(c2), .out_data(d2),
        .occupancy(o2), .stall_cnt(s2)
    );

    always_comb begin
        s_ready = r0; s_valid = v0; s_ctrl = c0;
        s_data  = d0; s_occ   = o0; s_stall = s0;
        if (sel == 1) begin
            s_ready = r1; s_valid = v1; s_ctrl = c1;
            s_data  = d1; s_occ   = o1; s_stall = {12'b0, s1};
        end else if (sel == 2) begin
            s_ready = r2; s_valid = v2; s_ctrl = c2;
            s_data  = d2; s_occ   = o2; s_stall = s2;
        end
    end

    function automatic logic m_ready();
        if (skid_mode) return (q.size() < 2);
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic drive(input logic v, input logic [9:0] c,
                         input logic [31:0] d, input logic r,
                         input logic f);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    // Advance the model by one clock edge, then move to the next negedge.
    task automatic tick();
        logic acc, iss;
        acc = in_valid && m_ready();
        iss = (q.size() != 0) && out_ready;
        if (q.size() != 0 && !out_ready && stall_exp < cnt_max)
            stall_exp++;
        if (flush) begin
            q.delete();
        end else begin
            if (iss) void'(q.pop_front());
            if (acc) q.push_back({in_ctrl, in_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int s);
        sel       = s;
        skid_mode = (s != 2);
        cnt_max   = (s == 1) ? 15 : 65535;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        q.delete();
        stall_exp = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(0);
        drive(1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (s_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid got=%b exp=0", s_valid);
        end
        checks++;
        if (s_ctrl !== BUB) begin
            errors++; $display("FAIL rst_ctrl got=%h exp=%h", s_ctrl, BUB);
        end
        checks++;
        if (s_data !== 32'h0) begin
            errors++; $display("FAIL rst_data got=%h exp=0", s_data);
        end
        checks++;
        if (s_occ !== 2'd0) begin
            errors++; $display("FAIL rst_occ got=%0d exp=0", s_occ);
        end
        checks++;
        if (s_stall !== 16'd0) begin
            errors++; $display("FAIL rst_stall got=%0d exp=0", s_stall);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready got=%b exp=1", s_ready);
        end
    endtask

    task automatic test_streaming();
        do_reset(0);
        for (int i = 1; i <= 9; i++) begin
            drive(i <= 8, 10'(i), 32'(i), 1'b1, 1'b0);
            if (i > 1) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== 32'(i - 1)) begin
                    errors++;
                    $display("FAIL stream_data i=%0d got=%b/%0d exp=1/%0d",
                             i, s_valid, s_data, i - 1);
                end
            end
            checks++;
            if (s_occ > 2'd1 || s_stall !== 16'd0) begin
                errors++;
                $display("FAIL stream_occ i=%0d occ=%0d stall=%0d exp<=1/0",
                         i, s_occ, s_stall);
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        do_reset(0);
        drive(1'b1, 10'h0A, 32'hAAAA_0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 10'h0B, 32'hBBBB_0002, 1'b0, 1'b0);
        checks++;
        if (s_ready !== 1'b1 || s_data !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL bp_busy ready=%b data=%h exp=1/aaaa0001",
                     s_ready, s_data);
        end
        tick();
        drive(1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (s_ready !== 1'b0 || s_occ !== 2'd2 || s_stall !== 16'd1) begin
            errors++;
            $display("FAIL bp_full ready=%b occ=%0d stall=%0d exp=0/2/1",
                     s_ready, s_occ, s_stall);
        end
        tick();
        drive(1'b0, 10'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 32'hAAAA_0001 ||
            s_stall !== 16'd2) begin
            errors++;
            $display("FAIL bp_relA valid=%b data=%h stall=%0d exp=1/aaaa0001/2",
                     s_valid, s_data, s_stall);
        end
        tick();
        drive(1'b0, 10'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 32'hBBBB_0002 ||
            s_ctrl !== 10'h0B || s_occ !== 2'd1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_relB v=%b d=%h c=%h occ=%0d rdy=%b exp=1/bbbb0002/0b/1/1",
                     s_valid, s_data, s_ctrl, s_occ, s_ready);
        end
        tick();
        drive(1'b0, 10'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (s_valid !== 1'b0 || s_occ !== 2'd0 || s_stall !== 16'd2) begin
            errors++;
            $display("FAIL bp_drain v=%b occ=%0d stall=%0d exp=0/0/2",
                     s_valid, s_occ, s_stall);
        end
    endtask

    task automatic test_flush();
        do_reset(0);
        drive(1'b1, 10'h0A, 32'hAAAA_0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 10'h0B, 32'hBBBB_0002, 1'b0, 1'b0);
        tick();
        drive(1'b1, 10'h0C, 32'hCCCC_0003, 1'b0, 1'b1);
        checks++;
        if (s_occ !== 2'd2) begin
            errors++; $display("FAIL fl_pre occ=%0d exp=2", s_occ);
        end
        tick();
        drive(1'b0, 10'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (s_valid !== 1'b0 || s_ctrl !== BUB || s_occ !== 2'd0 ||
            s_ready !== 1'b1) begin
            errors++;
            $display("FAIL fl_post v=%b c=%h occ=%0d rdy=%b exp=0/%h/0/1",
                     s_valid, s_ctrl, s_occ, s_ready, BUB);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b0, 10'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (s_valid !== 1'b0 || s_data === 32'hCCCC_0003) begin
                errors++;
                $display("FAIL fl_ghost i=%0d v=%b d=%h exp=0/not-C",
                         i, s_valid, s_data);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(0);
        drive(1'b1, 10'h11, 32'h1111_1111, 1'b0, 1'b0);
        tick();
        drive(1'b1, 10'h22, 32'h2222_2222, 1'b0, 1'b0);
        tick();
        drive(1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if (s_valid !== 1'b0 || s_ctrl !== BUB || s_data !== 32'h0 ||
            s_occ !== 2'd0 || s_stall !== 16'd0) begin
            errors++;
            $display("FAIL arst v=%b c=%h d=%h occ=%0d st=%0d exp=0/%h/0/0/0",
                     s_valid, s_ctrl, s_data, s_occ, s_stall, BUB);
        end
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        stall_exp = 0;
        drive(1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL arst_ready got=%b exp=1", s_ready);
        end
    endtask

    task automatic test_saturation();
        do_reset(1);
        drive(1'b1, 10'h33, 32'h3333_3333, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
            if (k == 10) begin
                checks++;
                if (s_stall !== 16'd10) begin
                    errors++; $display("FAIL sat_mid got=%0d exp=10", s_stall);
                end
            end
            tick();
        end
        drive(1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (s_stall !== 16'd15 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_end stall=%0d v=%b exp=15/1", s_stall, s_valid);
        end
    endtask

    task automatic test_no_skid();
        logic [9:0]  c;
        logic [31:0] d;
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            c = 10'($urandom);
            d = $urandom;
            drive(($urandom_range(0, 7) != 0), c, d, i[0], 1'b0);
            checks++;
            if (s_ready !== m_ready()) begin
                errors++;
                $display("FAIL ns_ready i=%0d got=%b exp=%b", i, s_ready, m_ready());
            end
            checks++;
            if (s_valid !== (q.size() != 0) || s_occ !== 2'(q.size())) begin
                errors++;
                $display("FAIL ns_occ i=%0d v=%b occ=%0d exp_occ=%0d",
                         i, s_valid, s_occ, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (s_data !== q[0].d || s_ctrl !== q[0].c) begin
                    errors++;
                    $display("FAIL ns_head i=%0d got=%h/%h exp=%h/%h",
                             i, s_ctrl, s_data, q[0].c, q[0].d);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        ent_t hold;
        bit   pend;
        do_reset(0);
        pend = 1'b0;
        hold = '0;
        for (int i = 0; i < 300; i++) begin
            if (!pend) hold = {10'($urandom), 32'($urandom)};
            pend = ($urandom_range(0, 3) != 0);
            drive(pend, hold.c, hold.d, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0));
            checks++;
            if (s_ready !== m_ready()) begin
                errors++;
                $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, s_ready, m_ready());
            end
            checks++;
            if (s_valid !== (q.size() != 0) || s_occ !== 2'(q.size())) begin
                errors++;
                $display("FAIL rnd_occ i=%0d v=%b occ=%0d exp_occ=%0d",
                         i, s_valid, s_occ, q.size());
            end
            checks++;
            if (s_ctrl !== ((q.size() != 0) ? q[0].c : BUB)) begin
                errors++;
                $display("FAIL rnd_ctrl i=%0d got=%h exp=%h", i, s_ctrl,
                         (q.size() != 0) ? q[0].c : BUB);
            end
            if (q.size() != 0) begin
                checks++;
                if (s_data !== q[0].d) begin
                    errors++;
                    $display("FAIL rnd_data i=%0d got=%h exp=%h", i, s_data, q[0].d);
                end
            end
            checks++;
            if (s_stall !== 16'(stall_exp)) begin
                errors++;
                $display("FAIL rnd_stall i=%0d got=%0d exp=%0d", i, s_stall, stall_exp);
            end
            if (pend && m_ready()) pend = 1'b0;
            if (flush) pend = 1'b0;
            tick();
        end
    endtask

    initial begin
        sel       = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        skid_mode = 1'b1;
        cnt_max   = 65535;
        stall_exp = 0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_no_skid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
